// File: rtl/state_machine_pkg.sv
// Shared definitions for the baccarat dealing controller: state encoding and score thresholds.
package state_machine_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PC1    = 3'b000,
    DC1    = 3'b001,
    PC2    = 3'b010,
    DC2    = 3'b011,
    PC3    = 3'b100,
    DC3    = 3'b101,
    WIN    = 3'b110,
    UNUSED = 3'b111
  } state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

endpackage

// File: rtl/state_machine_dealer_draw_rule.sv
// Decides whether the banker takes a third card, given the banker total and the player's third card.
module dealer_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/state_machine.sv
// Baccarat card-dealing controller: sequences the card load strobes and lights the winner.
module state_machine
  import state_machine_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_t state;
  state_t state_d;
  logic   dealerDraws;

  dealer_draw_rule u_dealer_draw_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (dealerDraws)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state <= PC1;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d          = state;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state)
      PC1: begin
        load_pcard1 = 1'b1;
        state_d     = DC1;
      end
      DC1: begin
        load_dcard1 = 1'b1;
        state_d     = PC2;
      end
      PC2: begin
        load_pcard2 = 1'b1;
        state_d     = DC2;
      end
      DC2: begin
        load_dcard2 = 1'b1;
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_d = WIN;
        end else if (pscore <= DRAW_MAX) begin
          state_d = PC3;
        end else if (dscore <= DRAW_MAX) begin
          state_d = DC3;
        end else begin
          state_d = WIN;
        end
      end
      PC3: begin
        load_pcard3 = 1'b1;
        state_d     = dealerDraws ? DC3 : WIN;
      end
      DC3: begin
        load_dcard3 = 1'b1;
        state_d     = WIN;
      end
      // A tie lights both lamps, hence the inclusive compares.
      WIN: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        state_d          = WIN;
      end
      default: begin
        state_d = PC1;
      end
    endcase
  end

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench: directed hands followed by random play against a queue-based card-dealing model.
module tb_state_machine;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int assertCount = 0;
  int failCount   = 0;

  // Model: cards still to be dealt, 0..5 = p1,d1,p2,d2,p3,d3; empty queue means the hand is decided.
  int pending[$];
  bit modelValid = 1'b0;

  state_machine dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit bankerDraws(input int d, input int p3);
    return (d <= 2) || (d == 3 && p3 != 8) || (d >= 4 && d <= 6 && p3 >= 2 * (d - 3) && p3 <= 7);
  endfunction

  task automatic modelStep(input bit r, input int p, input int d, input int c);
    int cur;
    if (r) begin
      pending    = '{0, 1, 2, 3};
      modelValid = 1'b1;
    end else if (modelValid && pending.size() > 0) begin
      cur = pending.pop_front();
      if (cur == 3) begin
        if (p >= 8 || d >= 8) begin
        end else if (p <= 5) begin
          pending.push_back(4);
        end else if (d <= 5) begin
          pending.push_back(5);
        end
      end else if (cur == 4) begin
        if (bankerDraws(d, c)) pending.push_back(5);
      end
    end
  endtask

  task automatic compareModel();
    logic [5:0] loads;
    logic [5:0] expLoads;
    logic [2:0] expState;
    logic [1:0] expLights;
    int p, d;
    p = int'(pscore);
    d = int'(dscore);
    loads = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    if (pending.size() > 0) begin
      expState  = 3'(pending[0]);
      expLoads  = 6'(1 << pending[0]);
      expLights = 2'b00;
    end else begin
      expState  = 3'd6;
      expLoads  = 6'd0;
      expLights = {p > d || p == d, d > p || p == d};
    end
    checkOutput("state", 16'(dut.state), 16'(expState));
    checkOutput("loads", 16'(loads), 16'(expLoads));
    checkOutput("lights", 16'({player_win_light, dealer_win_light}), 16'(expLights));
  endtask

  task automatic applyStimulus(input bit r, input int p, input int d, input int c);
    @(negedge slow_clock);
    resetb = r;
    pscore = 4'(p);
    dscore = 4'(d);
    pcard3 = 4'(c);
    #1;
    if (modelValid) compareModel();
    @(posedge slow_clock);
    modelStep(r, p, d, c);
  endtask

  // Directed hands: each row is {resetb, pscore, dscore, pcard3} for one clock.
  typedef struct packed { bit r; logic [3:0] p; logic [3:0] d; logic [3:0] c; } row_t;
  row_t rows[$];

  task automatic addRows(input bit r, input int p, input int d, input int c, input int n);
    for (int i = 0; i < n; i++) rows.push_back('{r, 4'(p), 4'(d), 4'(c)});
  endtask

  initial begin
    resetb = 1'b1;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;

    addRows(1, 8, 5, 0, 2); addRows(0, 8, 5, 0, 6);
    addRows(1, 5, 8, 0, 1); addRows(0, 5, 8, 0, 5);
    addRows(1, 3, 7, 0, 1); addRows(0, 3, 7, 0, 4); addRows(0, 6, 7, 0, 2);
    addRows(1, 4, 6, 0, 1); addRows(0, 4, 6, 0, 4); addRows(0, 0, 6, 6, 1); addRows(0, 0, 4, 0, 2);
    addRows(1, 7, 5, 0, 1); addRows(0, 7, 5, 0, 4); addRows(0, 7, 6, 0, 2);
    addRows(1, 5, 6, 0, 1); addRows(0, 5, 6, 0, 4); addRows(0, 5, 6, 6, 1); addRows(0, 1, 1, 0, 2);
    addRows(1, 1, 1, 0, 1); addRows(0, 1, 1, 0, 1);
    addRows(1, 3, 3, 8, 1); addRows(0, 3, 3, 8, 4); addRows(0, 2, 3, 8, 2);

    foreach (rows[i]) applyStimulus(rows[i].r, int'(rows[i].p), int'(rows[i].d), int'(rows[i].c));

    for (int i = 0; i < 3000; i++) begin
      int lim;
      lim = ($urandom_range(0, 7) == 0) ? 15 : 9;
      applyStimulus($urandom_range(0, 19) == 0,
                    int'($urandom_range(0, lim)),
                    int'($urandom_range(0, lim)),
                    int'($urandom_range(0, lim)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/state_machine.md
STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 The module SHALL have port slow_clock, input, 1 bit: sole clock, rising-edge active.
REQ-002 The module SHALL have port resetb, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port pscore, input, 4 bits: player hand total, 0-9, from datapath.
REQ-004 The module SHALL have port dscore, input, 4 bits: dealer hand total, 0-9, from datapath.
REQ-005 The module SHALL have port pcard3, input, 4 bits: value of player third card, 0-9 (0 if not drawn).
REQ-006 The module SHALL have ports load_pcard1, load_pcard2 and load_pcard3, each an output of 1 bit: load strobe for player card 1/2/3 register.
REQ-007 The module SHALL have ports load_dcard1, load_dcard2 and load_dcard3, each an output of 1 bit: load strobe for dealer card 1/2/3 register.
REQ-008 The module SHALL have ports player_win_light and dealer_win_light, each an output of 1 bit: result lights.

Function
REQ-009 State encoding SHALL be 3 bits: PC1=000, DC1=001, PC2=010, DC2=011, PC3=100, DC3=101, WIN=110; the register SHALL be named state, for bench visibility.
REQ-010 Outputs SHALL be Moore-decoded from state only, except the win lights; each load_* SHALL be 1 only in its own state (PC1->load_pcard1 ... DC3->load_dcard3), and all others 0.
REQ-011 Fixed deal sequence: PC1->DC1->PC2->DC2, one state per clock, no conditions.
REQ-012 From DC2, with pscore/dscore sampled at that edge:
REQ-012a If pscore>=8 or dscore>=8 (natural), the next state SHALL be WIN.
REQ-012b Else if pscore<=5, the next state SHALL be PC3.
REQ-012c Else, with pscore of 6 or 7: if dscore<=5 the next state SHALL be DC3, otherwise WIN.
REQ-013 From PC3, the next state SHALL be DC3 if the dealer draw rule holds, otherwise WIN.
REQ-013a Dealer draw rule by dscore: 7 stand.
REQ-013b Dealer draw rule: 6 draw if pcard3 is in 6..7.
REQ-013c Dealer draw rule: 5 draw if pcard3 is in 4..7.
REQ-013d Dealer draw rule: 4 draw if pcard3 is in 2..7.
REQ-013e Dealer draw rule: 3 draw if pcard3 != 8.
REQ-013f Dealer draw rule: 0..2 always draw.
REQ-013g Dealer draw rule: >=8 stand.
REQ-014 From DC3, the next state SHALL be WIN unconditionally.
REQ-015 WIN SHALL be absorbing and held until reset.
REQ-016 In WIN, the lights SHALL be combinational on the current pscore/dscore: pscore>dscore gives player light only, dscore>pscore gives dealer light only, and equal gives both lights 1.
REQ-017 Outside WIN, both lights SHALL be 0.
REQ-018 Compares SHALL be unsigned 4-bit; inputs 10-15 SHALL get no special handling.
REQ-019 Unused encoding 111 SHALL drive all outputs 0 and SHALL go to PC1 next clock.
REQ-020 The WIN state SHALL be reached 4 clocks after reset release (natural or stand), 5 clocks via one of PC3/DC3, and 6 clocks via both.

Reset
REQ-021 When resetb=1 at a rising edge, state SHALL become PC1 regardless of current state, including mid-hand and in WIN.
REQ-022 After reset: load_pcard1=1; all other load_* SHALL be 0 and both lights SHALL be 0.
REQ-023 While resetb is held high, state SHALL remain PC1.

Structure
REQ-024 A shared package SHALL hold the state enum/constants and the state width (3).
REQ-025 One combinational sub-module, dealer_draw_rule (inputs dscore and pcard3, output draw), SHALL be used from the PC3 transition.
REQ-026 The design SHALL use a single state register and SHALL contain no other storage.

Verification
REQ-027 Player natural: after reset, with pscore=8 and dscore=5, after 4 clocks the state SHALL be WIN with player_win_light=1 and dealer_win_light=0, and SHALL remain WIN on a further clock.
REQ-028 Dealer natural: with pscore=5 and dscore=8, after 4 clocks the state SHALL be WIN with dealer light only.
REQ-029 Player draw, dealer stands: with pscore=3 and dscore=7, the state SHALL be PC3 after 4 clocks with load_pcard3=1; after setting pscore=6 and pcard3=0, the state SHALL be WIN after 1 clock with dealer light only.
REQ-030 Both draw: with pscore=4 and dscore=6, the state SHALL be PC3; after setting pscore=0 and pcard3=6, the state SHALL be DC3 (load_dcard3=1); after 1 clock the state SHALL be WIN, and with dscore=4 the dealer light only.
REQ-031 Player stands, dealer draws: with pscore=7 and dscore=5, the state SHALL be DC3 after 4 clocks; with dscore=6, the next clock SHALL give WIN with player light only.
REQ-032 Tie and reset: with pscore=5 and dscore=6 the state SHALL go to PC3; with pcard3=6 it SHALL go to DC3; with pscore=dscore=1 it SHALL go to WIN with both lights 1; asserting resetb for 1 clock SHALL give PC1 with load_pcard1=1.
